avalon_st_sink_interface: RTL and testbench
===========================================

Name: avalon_st_sink_interface

Overview:
- Avalon-ST sink front end of the video IP.
- Accepts the 16-bit pixel stream from the upstream video DMA source (ready/valid, startofpacket/endofpacket, readyLatency 0).
- Buffers the stream in a small FIFO, enforces packet framing, and presents pixels to the IP core with their x/y position.
- Pairs with the IP's Avalon-ST source interface on the output side.

Parameters:
- DATA_W, 16, pixel width (RGB565).
- FIFO_DEPTH, 4, buffer entries; power of 2, minimum 2.
- FRAME_W, 640, pixels per line.
- FRAME_H, 480, lines per frame.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  upstream beat valid.
- ready_out  out  1  sink ready to upstream.
- data_sink  in  DATA_W  upstream pixel data.
- startofpacket_in  in  1  first beat of frame.
- endofpacket_in  in  1  last beat of frame.
- pixel_data  out  DATA_W  head-of-FIFO pixel.
- pixel_valid  out  1  head entry present.
- pixel_ready  in  1  IP core consumes head.
- pixel_sop  out  1  head is SOP.
- pixel_eop  out  1  head is EOP.
- pixel_x  out  16  column of head pixel.
- pixel_y  out  16  line of head pixel.
- sop_error  out  1  one-cycle pulse on a framing violation.
- size_error  out  1  one-cycle pulse on a frame size mismatch (FRAME_CHECK_EN only).
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty; state IDLE; counters 0; every output 0 except ready_out, which also stays 0 while reset is asserted.
- Input handshake:
  - ready_out = !full, combinational from registered occupancy.
  - A transfer occurs when valid_in && ready_out. Data is not sampled otherwise.
  - With FIFO full, ready_out=0 even if pixel_ready=1 the same cycle. There is no pass-through.
- FIFO:
  - Entry = {sop, eop, data}.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency from accepted beat to pixel_valid = 1 cycle.
- Output side:
  - pixel_valid = !empty.
  - A pop occurs when pixel_valid && pixel_ready.
  - pixel_data, pixel_sop and pixel_eop come straight from the head entry.
- Framing FSM (input side):
  - IDLE, beat with SOP: write it. If EOP is also set (single-beat packet), stay IDLE; otherwise go to IN_FRAME.
  - IDLE, beat without SOP: accept it (ready honoured), drop it (not written), pulse sop_error.
  - IN_FRAME, beat without SOP: write it. EOP -> IDLE.
  - IN_FRAME, beat with SOP (premature restart): write it, pulse sop_error, stay IN_FRAME. If EOP is also set, go to IDLE.
- Position counters (output side):
  - pixel_x/pixel_y are forced to 0 while the head is SOP.
  - Otherwise they show the internal counters, which hold the position of the next popped beat.
  - On popping an EOP beat, counters go to 0,0.
  - On popping a SOP beat that is not EOP, counters go to (1,0), or (0,1) if FRAME_W=1.
  - On any other pop, x increments; at FRAME_W-1, x wraps to 0 and y increments.
  - y saturates at FRAME_H-1 (no wrap).
- Reset mid-frame: all buffered beats are discarded. The next frame must start with SOP; beats before it trigger the drop/sop_error rule.

Optional Feature:
- Macro: FRAME_CHECK_EN.
- When defined: a beat counter counts popped beats per frame.
  - It restarts at 1 on a popped SOP.
  - When an EOP pops, count != FRAME_W*FRAME_H pulses size_error the cycle after the pop.
  - The counter saturates at its maximum value.
- When not defined: size_error is tied to 0 and no counter logic is present.

Decomposition:
- Shared package video_ip_pkg: DATA_W default, FRAME_W/FRAME_H defaults, FSM state encoding (IDLE, IN_FRAME), FIFO entry field offsets.
- Sub-module: video_st_fifo, a synchronous FIFO with full/empty/level outputs. The framing FSM and counters stay in the top module.

Test Plan:
- Reset, then a 4-beat frame (SOP on 0x0001, data 0x0002, 0x0003, EOP on 0x0004) with FRAME_W=2, FRAME_H=2 and pixel_ready=1 -> pixels out in order at (0,0),(1,0),(0,1),(1,1); no error pulses.
- pixel_ready=0 while 4 beats are pushed with FIFO_DEPTH=4 -> ready_out falls the cycle after the 4th accept and fifo_level=4. Then set pixel_ready=1 -> one pop per cycle and ready_out returns the cycle after the first pop.
- Beat 0xBEEF without SOP while IDLE -> accepted and dropped; sop_error high for exactly 1 cycle; pixel_valid stays 0.
- SOP arrives on beat 3 of a frame -> sop_error pulse; the new SOP head shows (0,0) and the old frame's beats drain first.
- reset asserted mid-frame with 3 entries buffered -> pixel_valid=0 and fifo_level=0 immediately (asynchronous). After release, a non-SOP beat is dropped.
- With FRAME_CHECK_EN defined and FRAME_W=2, FRAME_H=2, send a 3-beat frame -> size_error pulses once, the cycle after the EOP pop.

Source files
------------

// File: rtl/video_ip_pkg.sv
// -----------------------------------------------------------------------------
// video_ip_pkg
// Shared definitions for the video IP Avalon-ST front end:
//   - default pixel width and frame geometry
//   - framing FSM state encoding
//   - FIFO entry layout {sop, eop, data}; sop/eop offsets are relative to the
//     top of the data field, so an entry is data_w + 2 bits wide.
// -----------------------------------------------------------------------------
package video_ip_pkg;

   localparam int DATA_W_DEF     = 16;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int FRAME_W_DEF    = 640;
   localparam int FRAME_H_DEF    = 480;

   // Framing state of the input side.
   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_IN_FRAME = 1'b1
   } frame_state_e;

   // Entry field offsets above the data field: entry = {sop, eop, data}.
   localparam int ENTRY_EOP_OFS = 0;
   localparam int ENTRY_SOP_OFS = 1;

   function automatic int entry_w(input int data_w);
      return data_w + 2;
   endfunction

endpackage

// File: rtl/video_st_fifo.sv
// -----------------------------------------------------------------------------
// video_st_fifo
// Synchronous FIFO, show-ahead (head entry visible on rdata while !empty).
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (empties the FIFO)
//   push   in   write wdata (ignored when full)
//   pop    in   drop the head entry (ignored when empty)
//   wdata  in   WIDTH entry to write
//   rdata  out  head entry
//   full   out  level == DEPTH
//   empty  out  level == 0
//   level  out  occupancy, 0..DEPTH
// DEPTH must be a power of 2 (>= 2) so pointers wrap naturally.
// -----------------------------------------------------------------------------
module video_st_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q,  level_d;
   logic             push_ok,  pop_ok;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop  && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: an entry is only observed once it is written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/avalon_st_sink_interface.sv
// -----------------------------------------------------------------------------
// avalon_st_sink_interface
// Avalon-ST sink front end of the video IP (readyLatency 0). Buffers the
// upstream pixel stream, enforces SOP/EOP framing and presents each head
// pixel to the IP core with its x/y position.
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-low reset
//   valid_in         in   upstream beat valid
//   ready_out        out  sink can accept (FIFO not full, out of reset)
//   data_sink        in   upstream pixel
//   startofpacket_in in   first beat of frame
//   endofpacket_in   in   last beat of frame
//   pixel_data/sop/eop  out  head FIFO entry (0 when empty)
//   pixel_valid      out  FIFO not empty
//   pixel_ready      in   IP core consumes the head
//   pixel_x/pixel_y  out  position of head pixel
//   sop_error        out  one-cycle pulse after a framing violation is accepted
//   size_error       out  one-cycle pulse after an EOP pops from a frame of the
//                         wrong size (only with FRAME_CHECK_EN defined)
//   fifo_level       out  FIFO occupancy
// Optional feature macro: FRAME_CHECK_EN (popped-beat frame size check).
// -----------------------------------------------------------------------------
module avalon_st_sink_interface
   import video_ip_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int FRAME_W    = FRAME_W_DEF,
   parameter int FRAME_H    = FRAME_H_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        valid_in,
   output logic                        ready_out,
   input  logic [DATA_W-1:0]           data_sink,
   input  logic                        startofpacket_in,
   input  logic                        endofpacket_in,
   output logic [DATA_W-1:0]           pixel_data,
   output logic                        pixel_valid,
   input  logic                        pixel_ready,
   output logic                        pixel_sop,
   output logic                        pixel_eop,
   output logic [15:0]                 pixel_x,
   output logic [15:0]                 pixel_y,
   output logic                        sop_error,
   output logic                        size_error,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int          ENTRY_W = entry_w(DATA_W);
   localparam int          SOP_BIT = DATA_W + ENTRY_SOP_OFS;
   localparam int          EOP_BIT = DATA_W + ENTRY_EOP_OFS;
   localparam logic [15:0] X_LAST  = 16'(FRAME_W - 1);
   localparam logic [15:0] Y_LAST  = 16'(FRAME_H - 1);

   // Valid/ready: a beat moves on a port in any cycle where both valid and
   // ready are high at the rising edge; data is ignored otherwise. ready_out
   // depends only on registered occupancy (and reset), never on pixel_ready.

   frame_state_e       state_q, state_d;
   logic               sop_err_q, sop_err_d;
   logic [15:0]        x_q, x_d;
   logic [15:0]        y_q, y_d;

   logic               accept;
   logic               fifo_push, fifo_pop;
   logic               fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] wr_entry, head;
   logic               head_sop, head_eop;

   assign ready_out   = reset && !fifo_full;
   assign accept      = valid_in && ready_out;
   assign pixel_valid = !fifo_empty;
   assign fifo_pop    = pixel_valid && pixel_ready;

   assign head_sop    = pixel_valid && head[SOP_BIT];
   assign head_eop    = pixel_valid && head[EOP_BIT];
   assign pixel_sop   = head_sop;
   assign pixel_eop   = head_eop;
   assign pixel_data  = pixel_valid ? head[DATA_W-1:0] : '0;
   assign pixel_x     = head_sop ? 16'd0 : x_q;
   assign pixel_y     = head_sop ? 16'd0 : y_q;
   assign sop_error   = sop_err_q;

   always_comb begin
      wr_entry                = '0;
      wr_entry[DATA_W-1:0]    = data_sink;
      wr_entry[SOP_BIT]       = startofpacket_in;
      wr_entry[EOP_BIT]       = endofpacket_in;
   end

   video_st_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (wr_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Framing FSM. Orphan beats in IDLE are still handshaken (so upstream is
   // never stalled) but are not written. A premature SOP inside a frame is
   // kept: it starts the new frame at the output side.
   always_comb begin
      state_d   = state_q;
      fifo_push = 1'b0;
      sop_err_d = 1'b0;
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (startofpacket_in) begin
                  fifo_push = 1'b1;
                  state_d   = endofpacket_in ? ST_IDLE : ST_IN_FRAME;
               end else begin
                  sop_err_d = 1'b1;
               end
            end
            ST_IN_FRAME: begin
               fifo_push = 1'b1;
               sop_err_d = startofpacket_in;
               if (endofpacket_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Position of the next beat to pop. An SOP head always shows (0,0) via the
   // output mux, so the counters only need to describe the beat after it.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (fifo_pop) begin
         if (head_eop) begin
            x_d = 16'd0;
            y_d = 16'd0;
         end else if (head_sop) begin
            if (FRAME_W == 1) begin
               x_d = 16'd0;
               y_d = (Y_LAST != 16'd0) ? 16'd1 : 16'd0;
            end else begin
               x_d = 16'd1;
               y_d = 16'd0;
            end
         end else if (x_q >= X_LAST) begin
            x_d = 16'd0;
            y_d = (y_q < Y_LAST) ? y_q + 16'd1 : y_q;
         end else begin
            x_d = x_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         sop_err_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         state_q   <= state_d;
         sop_err_q <= sop_err_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

`ifdef FRAME_CHECK_EN
   localparam int FRAME_PIX = FRAME_W * FRAME_H;
   // One spare bit so a saturated count can never alias to FRAME_PIX.
   localparam int CNT_W     = $clog2(FRAME_PIX + 1) + 1;

   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, beat_cnt_next;
   logic             size_err_q, size_err_d;

   always_comb begin
      // Count including the beat being popped this cycle.
      beat_cnt_next = head_sop ? CNT_W'(1)
                    : ((&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_W'(1));
      beat_cnt_d    = fifo_pop ? beat_cnt_next : beat_cnt_q;
      size_err_d    = fifo_pop && head_eop && (beat_cnt_next != CNT_W'(FRAME_PIX));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt_q <= '0;
         size_err_q <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         size_err_q <= size_err_d;
      end
   end

   assign size_error = size_err_q;
`else
   assign size_error = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_st_sink_interface.sv
// -----------------------------------------------------------------------------
// tb_avalon_st_sink_interface
// Directed + randomized bench for avalon_st_sink_interface with FIFO_DEPTH=4,
// FRAME_W=2, FRAME_H=2. A reference model tracks the buffered beats as a
// queue, framing as an in-frame flag, and the output position as the index of
// the beat within its frame. Every cycle all outputs are checked.
// -----------------------------------------------------------------------------
module tb_avalon_st_sink_interface;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int FW    = 2;
   localparam int FH    = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid_in = 1'b0;
   logic          ready_out;
   logic [DW-1:0] data_sink = '0;
   logic          startofpacket_in = 1'b0;
   logic          endofpacket_in = 1'b0;
   logic [DW-1:0] pixel_data;
   logic          pixel_valid;
   logic          pixel_ready = 1'b0;
   logic          pixel_sop;
   logic          pixel_eop;
   logic [15:0]   pixel_x;
   logic [15:0]   pixel_y;
   logic          sop_error;
   logic          size_error;
   logic [LW-1:0] fifo_level;

   always #5 clk = ~clk;

   avalon_st_sink_interface #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .FRAME_W    (FW),
      .FRAME_H    (FH)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .valid_in         (valid_in),
      .ready_out        (ready_out),
      .data_sink        (data_sink),
      .startofpacket_in (startofpacket_in),
      .endofpacket_in   (endofpacket_in),
      .pixel_data       (pixel_data),
      .pixel_valid      (pixel_valid),
      .pixel_ready      (pixel_ready),
      .pixel_sop        (pixel_sop),
      .pixel_eop        (pixel_eop),
      .pixel_x          (pixel_x),
      .pixel_y          (pixel_y),
      .sop_error        (sop_error),
      .size_error       (size_error),
      .fifo_level       (fifo_level)
   );

   // ---------------- scoreboard / reference model ----------------
   int               errors = 0;
   int               checks = 0;
   logic [DW+1:0]    exp_q[$];      // {sop, eop, data}
   bit               m_in_frame = 1'b0;
   int               m_idx = 0;     // index of next popped beat in its frame
   int               m_cnt = 0;     // beats popped so far in current frame
   bit               exp_sop_err = 1'b0;
   bit               exp_size_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      bit  exp_v;
      bit  hs;
      int  ex, ey;
      exp_v = (exp_q.size() != 0);
      hs    = exp_v && exp_q[0][DW+1];
      ex    = hs ? 0 : (m_idx % FW);
      ey    = hs ? 0 : ((m_idx / FW) < FH - 1 ? (m_idx / FW) : FH - 1);
      check("ready_out",   32'(ready_out),   32'(reset && exp_q.size() < DEPTH));
      check("pixel_valid", 32'(pixel_valid), 32'(exp_v));
      check("fifo_level",  32'(fifo_level),  32'(exp_q.size()));
      if (exp_v) begin
         check("pixel_data", 32'(pixel_data), 32'(exp_q[0][DW-1:0]));
         check("pixel_sop",  32'(pixel_sop),  32'(exp_q[0][DW+1]));
         check("pixel_eop",  32'(pixel_eop),  32'(exp_q[0][DW]));
      end
      check("pixel_x",    32'(pixel_x),    32'(ex));
      check("pixel_y",    32'(pixel_y),    32'(ey));
      check("sop_error",  32'(sop_error),  32'(exp_sop_err));
      check("size_error", 32'(size_error), 32'(exp_size_err));
   endtask

   // One clock: predict handshakes from pre-edge state, advance, check.
   task automatic tick();
      bit            acc, pop, s, e, hs, he;
      int            cnt_at;
      logic [DW+1:0] head;
      acc = valid_in && reset && (exp_q.size() < DEPTH);
      pop = reset && (exp_q.size() > 0) && pixel_ready;
      s   = startofpacket_in;
      e   = endofpacket_in;
      @(posedge clk);
      #1;
      exp_sop_err  = 1'b0;
      exp_size_err = 1'b0;
      if (pop) begin
         head = exp_q.pop_front();
         hs   = head[DW+1];
         he   = head[DW];
         cnt_at = hs ? 1 : m_cnt + 1;
         if (he) begin
`ifdef FRAME_CHECK_EN
            exp_size_err = (cnt_at != FW * FH);
`endif
            m_idx = 0;
            m_cnt = 0;
         end else begin
            m_idx = hs ? 1 : m_idx + 1;
            m_cnt = cnt_at;
         end
      end
      if (acc) begin
         if (!m_in_frame) begin
            if (s) begin
               exp_q.push_back({s, e, data_sink});
               m_in_frame = !e;
            end else begin
               exp_sop_err = 1'b1;
            end
         end else begin
            exp_q.push_back({s, e, data_sink});
            if (s) exp_sop_err = 1'b1;
            if (e) m_in_frame = 1'b0;
         end
      end
      check_outputs();
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input bit s, input bit e, input logic [DW-1:0] d);
      valid_in         = v;
      startofpacket_in = s;
      endofpacket_in   = e;
      data_sink        = d;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_in_frame   = 1'b0;
      m_idx        = 0;
      m_cnt        = 0;
      exp_sop_err  = 1'b0;
      exp_size_err = 1'b0;
   endtask

   // Assert reset between clock edges and check the immediate effect.
   task automatic async_reset();
      #2;
      reset = 1'b0;
      #1;
      model_clear();
      check_outputs();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state.
      model_clear();
      #1;
      check_outputs();
      idle(2);
      reset = 1'b1;
      idle(1);

      // Four-beat frame streaming straight through.
      pixel_ready = 1'b1;
      drive(1, 1, 0, 16'h0001);
      drive(1, 0, 0, 16'h0002);
      drive(1, 0, 0, 16'h0003);
      drive(1, 0, 1, 16'h0004);
      idle(2);

      // Backpressure: fill the FIFO, hold upstream, then drain.
      pixel_ready = 1'b0;
      drive(1, 1, 0, 16'h0011);
      drive(1, 0, 0, 16'h0012);
      drive(1, 0, 0, 16'h0013);
      drive(1, 0, 1, 16'h0014);
      drive(1, 1, 1, 16'h0015);   // refused while full
      drive(1, 1, 1, 16'h0015);
      pixel_ready = 1'b1;
      drive(1, 1, 1, 16'h0015);   // pop frees a slot, still not ready this cycle
      drive(1, 1, 1, 16'h0015);
      idle(6);

      // Orphan beat while IDLE is dropped.
      drive(1, 0, 0, 16'hBEEF);
      idle(2);

      // Premature SOP on beat 3.
      drive(1, 1, 0, 16'h0021);
      drive(1, 0, 0, 16'h0022);
      drive(1, 1, 0, 16'h0031);
      drive(1, 0, 0, 16'h0032);
      drive(1, 0, 0, 16'h0033);
      drive(1, 0, 1, 16'h0034);
      idle(3);

      // Over-long frame: y saturates at FH-1, x keeps wrapping.
      pixel_ready = 1'b0;
      drive(1, 1, 0, 16'h0041);
      pixel_ready = 1'b1;
      for (int i = 0; i < 6; i++) drive(1, 0, 0, 16'(16'h0042 + i));
      drive(1, 0, 1, 16'h0048);
      idle(4);

      // Short frame (3 beats) and a single-beat frame.
      drive(1, 1, 0, 16'h0051);
      drive(1, 0, 0, 16'h0052);
      drive(1, 0, 1, 16'h0053);
      drive(1, 1, 1, 16'h0061);
      idle(4);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         pixel_ready = ($urandom_range(0, 3) != 0);
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 4) == 0), 16'($urandom));
      end
      pixel_ready = 1'b1;
      idle(8);
      // Close any open frame so the next section starts IDLE.
      drive(1, 0, 1, 16'h0070);
      idle(6);

      // Reset mid-frame with three beats buffered.
      pixel_ready = 1'b0;
      drive(1, 1, 0, 16'h0081);
      drive(1, 0, 0, 16'h0082);
      drive(1, 0, 0, 16'h0083);
      valid_in = 1'b0;
      async_reset();
      idle(2);
      reset = 1'b1;
      pixel_ready = 1'b1;
      drive(1, 0, 0, 16'h0090);   // dropped: no SOP since reset
      drive(1, 1, 0, 16'h0091);
      drive(1, 0, 0, 16'h0092);
      drive(1, 0, 0, 16'h0093);
      drive(1, 0, 1, 16'h0094);
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
